// File: rtl/multdiv_unit.sv
// Iterative signed multiply/divide unit: shift-add multiply and restoring divide on
// operand magnitudes, one radix-2 step per clock, sign applied in a final fix-up cycle.
module multdiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_mult,
    input  logic             ctrl_div,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic [WIDTH-1:0] result,
    output logic             exception,
    output logic             result_ready,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    // LOAD is performed on the acceptance edge itself, so it is never held as a state.
    typedef enum logic [1:0] {IDLE, LOAD, ITER, FIX} state_t;

    state_t state, state_next;

    logic               start;
    logic               op_div;
    logic               neg;
    logic               div_zero;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   addend;
    logic [2*WIDTH-1:0] acc;

    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shifted;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH:0]     prod_top;
    logic               mul_exc;
    logic [WIDTH-1:0]   quo_s;
    logic               div_exc;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        case (state)
            IDLE: begin
                if (ctrl_mult || ctrl_div) begin
                    start      = 1'b1;
                    state_next = (!ctrl_mult && operand_b == '0) ? FIX : ITER;
                end
            end
            ITER:    if (count == CW'(WIDTH - 1)) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // MIN maps onto itself, which is its correct unsigned magnitude.
    assign abs_a = operand_a[WIDTH-1] ? -operand_a : operand_a;
    assign abs_b = operand_b[WIDTH-1] ? -operand_b : operand_b;

    assign mul_sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, addend} : '0);
    assign div_shifted = acc[2*WIDTH-1:WIDTH-1];
    assign div_ge      = div_shifted >= {1'b0, addend};
    assign div_rem     = WIDTH'(div_shifted - {1'b0, addend});

    // acc high half holds the partial product / remainder, low half the multiplier / quotient.
    always_comb begin
        if (!op_div)     acc_step = {mul_sum, acc[WIDTH-1:1]};
        else if (div_ge) acc_step = {div_rem, acc[WIDTH-2:0], 1'b1};
        else             acc_step = {acc[2*WIDTH-2:0], 1'b0};
    end

    assign prod_s   = neg ? -acc : acc;
    assign prod_top = prod_s[2*WIDTH-1:WIDTH-1];
    assign mul_exc  = !((&prod_top) || !(|prod_top));
    assign quo_s    = neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign div_exc  = !neg && acc[WIDTH-1];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            op_div       <= 1'b0;
            neg          <= 1'b0;
            div_zero     <= 1'b0;
            count        <= '0;
            addend       <= '0;
            acc          <= '0;
            result       <= '0;
            exception    <= 1'b0;
            result_ready <= 1'b0;
        end else begin
            result_ready <= (state == FIX);
            if (start) begin
                op_div   <= !ctrl_mult;
                neg      <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
                div_zero <= !ctrl_mult && (operand_b == '0);
                count    <= '0;
                if (ctrl_mult) begin
                    addend <= abs_a;
                    acc    <= {{WIDTH{1'b0}}, abs_b};
                end else begin
                    addend <= abs_b;
                    acc    <= {{WIDTH{1'b0}}, abs_a};
                end
            end else if (state == ITER) begin
                acc   <= acc_step;
                count <= count + CW'(1);
            end
            if (state == FIX) begin
                if (div_zero) begin
                    result    <= '0;
                    exception <= 1'b1;
                end else if (op_div) begin
                    result    <= quo_s;
                    exception <= div_exc;
                end else begin
                    result    <= prod_s[WIDTH-1:0];
                    exception <= mul_exc;
                end
            end
        end
    end

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed bench for multdiv_unit at WIDTH=32 and WIDTH=8; expectations are queued at
// launch and checked (value, flag, ready edge) when result_ready is seen.
module tb_multdiv_unit;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int unsigned due;
        string       tag;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        m32, d32, e32, rdy32, busy32;
    logic [31:0] a32, b32, r32;
    logic        m8, d8, e8, rdy8, busy8;
    logic [7:0]  a8, b8, r8;

    int unsigned total = 0;
    int unsigned bad = 0;
    int unsigned cyc = 0;
    exp_t q32[$];
    exp_t q8[$];
    exp_t x32, x8;

    always @(posedge clk) cyc <= cyc + 1;

    multdiv_unit #(.WIDTH(32)) u_dut32 (
        .clock(clk), .reset(rst_n), .ctrl_mult(m32), .ctrl_div(d32),
        .operand_a(a32), .operand_b(b32), .result(r32), .exception(e32),
        .result_ready(rdy32), .busy(busy32)
    );

    multdiv_unit #(.WIDTH(8)) u_dut8 (
        .clock(clk), .reset(rst_n), .ctrl_mult(m8), .ctrl_div(d8),
        .operand_a(a8), .operand_b(b8), .result(r8), .exception(e8),
        .result_ready(rdy8), .busy(busy8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (rdy32) begin
            check("ready32_pending", 32'(q32.size() > 0), 32'd1);
            if (q32.size() > 0) begin
                x32 = q32.pop_front();
                check({x32.tag, "_result"}, r32, x32.res);
                check({x32.tag, "_exc"}, {31'd0, e32}, {31'd0, x32.exc});
                check({x32.tag, "_ready_edge"}, cyc, x32.due);
            end
        end
        if (rdy8) begin
            check("ready8_pending", 32'(q8.size() > 0), 32'd1);
            if (q8.size() > 0) begin
                x8 = q8.pop_front();
                check({x8.tag, "_result"}, {24'd0, r8}, x8.res);
                check({x8.tag, "_exc"}, {31'd0, e8}, {31'd0, x8.exc});
                check({x8.tag, "_ready_edge"}, cyc, x8.due);
            end
        end
    end

    // Called on a negedge; the start is accepted on the following posedge.
    task automatic go32(input bit mul, input bit div, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic ee, input int unsigned lat, input string tag);
        exp_t e;
        m32 = mul; d32 = div; a32 = a; b32 = b;
        e.res = er; e.exc = ee; e.due = cyc + 1 + lat; e.tag = tag;
        q32.push_back(e);
        @(negedge clk);
        m32 = 1'b0; d32 = 1'b0; a32 = $urandom; b32 = $urandom;
    endtask

    task automatic go8(input bit mul, input bit div, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] er, input logic ee, input int unsigned lat, input string tag);
        exp_t e;
        m8 = mul; d8 = div; a8 = a; b8 = b;
        e.res = {24'd0, er}; e.exc = ee; e.due = cyc + 1 + lat; e.tag = tag;
        q8.push_back(e);
        @(negedge clk);
        m8 = 1'b0; d8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    endtask

    task automatic drain(input string tag);
        int unsigned n = 0;
        while ((q32.size() != 0 || q8.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(q32.size() + q8.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int unsigned nb;
        int unsigned n;
        rst_n = 1'b0;
        m32 = 1'b0; d32 = 1'b0; a32 = '0; b32 = '0;
        m8 = 1'b0; d8 = 1'b0; a8 = '0; b8 = '0;
        repeat (2) @(negedge clk);
        check("reset_result32", r32, 32'd0);
        check("reset_flags32", {29'd0, e32, rdy32, busy32}, 32'd0);
        check("reset_flags8", {21'd0, r8, e8, rdy8, busy8}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        go32(1'b1, 1'b0, 32'd7, -32'd6, 32'hFFFFFFD6, 1'b0, 33, "mul_7_x_m6");
        nb = 32'(busy32);
        repeat (40) begin
            @(negedge clk);
            nb += 32'(busy32);
        end
        check("mul_busy_cycles", nb, 32'd33);
        drain("drain_mul_basic");

        go32(1'b1, 1'b0, 32'h00010000, 32'h00010000, 32'h0, 1'b1, 33, "mul_ovf_2p32");
        drain("drain_mul_ovf");
        go32(1'b1, 1'b0, 32'h0, 32'h80000000, 32'h0, 1'b0, 33, "mul_zero_x_min");
        drain("drain_mul_zero");
        go32(1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, 33, "mul_min_x_m1");
        drain("drain_mul_min");

        go8(1'b1, 1'b0, 8'd12, 8'd11, 8'h84, 1'b1, 9, "mul8_12_x_11");
        drain("drain_mul8_a");
        go8(1'b1, 1'b0, -8'd8, 8'd16, 8'h80, 1'b0, 9, "mul8_m8_x_16");
        drain("drain_mul8_b");
        go8(1'b0, 1'b1, -8'd100, 8'd7, 8'hF2, 1'b0, 9, "div8_m100_7");
        drain("drain_div8_a");
        go8(1'b0, 1'b1, 8'h80, 8'hFF, 8'h80, 1'b1, 9, "div8_min_m1");
        drain("drain_div8_b");

        go32(1'b0, 1'b1, -32'd7, 32'd2, 32'hFFFFFFFD, 1'b0, 33, "div_m7_2");
        drain("drain_div_a");
        go32(1'b0, 1'b1, 32'd7, -32'd2, 32'hFFFFFFFD, 1'b0, 33, "div_7_m2");
        drain("drain_div_b");
        go32(1'b0, 1'b1, 32'd1, 32'd5, 32'd0, 1'b0, 33, "div_1_5");
        drain("drain_div_c");
        go32(1'b0, 1'b1, 32'h7FFFFFFF, 32'd1, 32'h7FFFFFFF, 1'b0, 33, "div_max_1");
        drain("drain_div_d");
        go32(1'b0, 1'b1, 32'd5, 32'd0, 32'd0, 1'b1, 1, "div_by_zero");
        drain("drain_dbz");
        go32(1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, 33, "div_min_m1");
        drain("drain_div_min");

        go32(1'b1, 1'b1, 32'd6, 32'd3, 32'd18, 1'b0, 33, "both_ctrl");
        drain("drain_both");

        go32(1'b0, 1'b1, 32'd100, 32'd7, 32'd14, 1'b0, 33, "b2b_first");
        n = 0;
        while (!rdy32 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("b2b_ready_seen", {31'd0, rdy32}, 32'd1);
        go32(1'b1, 1'b0, -32'd3, 32'd5, -32'd15, 1'b0, 33, "b2b_second");
        check("b2b_prev_held", r32, 32'd14);
        drain("drain_b2b");

        go32(1'b1, 1'b0, 32'd5, 32'd5, 32'd25, 1'b0, 33, "ignored_start");
        repeat (9) @(negedge clk);
        m32 = 1'b1; d32 = 1'b1; a32 = 32'd99; b32 = 32'd1;
        @(negedge clk);
        m32 = 1'b0; d32 = 1'b0;
        drain("drain_ignored");
        repeat (40) @(negedge clk);

        go32(1'b1, 1'b0, 32'd123, 32'd2, 32'd246, 1'b0, 33, "reset_victim");
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_result32", r32, 32'd0);
        check("midreset_flags32", {29'd0, e32, rdy32, busy32}, 32'd0);
        check("midreset_flags8", {21'd0, r8, e8, rdy8, busy8}, 32'd0);
        q32.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("no_pulse_after_reset", {31'd0, rdy32}, 32'd0);
        go32(1'b1, 1'b0, 32'd3, 32'd4, 32'd12, 1'b0, 33, "post_reset_mul");
        drain("drain_post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
